// File: rtl/ttw_mem_arb.sv
// rtl/ttw_mem_arb.sv - round-robin table-walker memory port arbiter with tag-routed responses
module ttw_mem_arb #(
    parameter int N      = 4,
    parameter int IDX_W  = 2,
    parameter int MCN_W  = 58,
    parameter int DATA_W = 512
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req_i_valid,
    output logic [N-1:0]         req_i_ready,
    input  logic [N*MCN_W-1:0]   req_i_mcn,
    output logic [N-1:0]         res_o_valid,
    output logic [DATA_W-1:0]    res_o_data,
    input  logic [N-1:0]         kill_i,
    output logic                 mem_req_o_valid,
    input  logic                 mem_req_o_ready,
    output logic [IDX_W-1:0]     mem_req_o_bits_idx,
    output logic [MCN_W-1:0]     mem_req_o_bits_mcn,
    input  logic                 mem_res_i_valid,
    output logic                 mem_res_i_ready,
    input  logic [IDX_W-1:0]     mem_res_i_bits_idx,
    input  logic [DATA_W-1:0]    mem_res_i_bits_data,
    output logic                 busy_o,
    output logic                 err_o
);

    logic [N-1:0]       pend_q, pend_d;
    logic [N-1:0]       kld_q, kld_d;
    logic [IDX_W-1:0]   rr_q;
    logic               rsp_rdy_q;
    logic               busy_q;
    logic               err_q;
    logic               req_vld_q;
    logic [IDX_W-1:0]   req_idx_q;
    logic [MCN_W-1:0]   req_mcn_q;
    logic [N-1:0]       res_vld_q;
    logic [DATA_W-1:0]  res_data_q;

    logic               slot_free;
    logic [N-1:0]       elig;
    logic               gnt_vld;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   scan_idx;
    logic [N-1:0]       gnt_oh;
    logic               grant;
    logic               rsp_acc;
    logic               rsp_pend;
    logic               rsp_dlv;
    logic [N-1:0]       rsp_oh;

    // The slot may be reloaded in the same cycle its current request is taken.
    assign slot_free = !req_vld_q || mem_req_o_ready;
    assign elig      = req_i_valid & ~pend_q;

    // Scan offsets from highest to lowest so the first eligible at or after rr_q wins.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int o = N - 1; o >= 0; o--) begin
            scan_idx = IDX_W'((int'(rr_q) + o) % N);
            if (elig[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    assign gnt_oh   = (gnt_vld && slot_free && !reset) ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    assign grant    = |gnt_oh;

    assign rsp_acc  = mem_res_i_valid && rsp_rdy_q;
    assign rsp_pend = pend_q[mem_res_i_bits_idx];
    assign rsp_oh   = {{(N-1){1'b0}}, 1'b1} << mem_res_i_bits_idx;
    assign rsp_dlv  = rsp_acc && rsp_pend && !kld_q[mem_res_i_bits_idx] && !kill_i[mem_res_i_bits_idx];

    // Pending/killed bookkeeping: kills only mark live requests, a response retires its tag,
    // and a grant never targets a pending tag so the set and clear cannot collide.
    always_comb begin
        pend_d = pend_q;
        kld_d  = kld_q | (kill_i & pend_q);
        if (rsp_acc && rsp_pend) begin
            pend_d = pend_d & ~rsp_oh;
            kld_d  = kld_d & ~rsp_oh;
        end
        pend_d = pend_d | gnt_oh;
    end

    // Registered slot, response delivery, round-robin pointer and status.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q     <= '0;
            kld_q      <= '0;
            rr_q       <= '0;
            rsp_rdy_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            req_vld_q  <= 1'b0;
            req_idx_q  <= '0;
            req_mcn_q  <= '0;
            res_vld_q  <= '0;
            res_data_q <= '0;
        end else begin
            pend_q    <= pend_d;
            kld_q     <= kld_d;
            rsp_rdy_q <= 1'b1;
            busy_q    <= |pend_d;
            if (rsp_acc && !rsp_pend) begin
                err_q <= 1'b1;
            end
            if (grant) begin
                req_vld_q <= 1'b1;
                req_idx_q <= gnt_idx;
                req_mcn_q <= req_i_mcn[gnt_idx*MCN_W +: MCN_W];
                rr_q      <= IDX_W'((int'(gnt_idx) + 1) % N);
            end else if (slot_free) begin
                req_vld_q <= 1'b0;
            end
            res_vld_q <= rsp_dlv ? rsp_oh : '0;
            if (rsp_dlv) begin
                res_data_q <= mem_res_i_bits_data;
            end
        end
    end

    assign req_i_ready        = gnt_oh;
    assign res_o_valid        = res_vld_q;
    assign res_o_data         = res_data_q;
    assign mem_req_o_valid    = req_vld_q;
    assign mem_req_o_bits_idx = req_idx_q;
    assign mem_req_o_bits_mcn = req_mcn_q;
    assign mem_res_i_ready    = rsp_rdy_q;
    assign busy_o             = busy_q;
    assign err_o              = err_q;

endmodule

// File: tb/tb_ttw_mem_arb.sv
// tb/tb_ttw_mem_arb.sv - randomized bench for ttw_mem_arb against a behavioural model
module tb_ttw_mem_arb;
    localparam int N      = 4;
    localparam int IDX_W  = 2;
    localparam int MCN_W  = 58;
    localparam int DATA_W = 512;

    logic                clock = 1'b0;
    logic                reset;
    logic [N-1:0]        req_i_valid;
    logic [N-1:0]        req_i_ready;
    logic [N*MCN_W-1:0]  req_i_mcn;
    logic [N-1:0]        res_o_valid;
    logic [DATA_W-1:0]   res_o_data;
    logic [N-1:0]        kill_i;
    logic                mem_req_o_valid;
    logic                mem_req_o_ready;
    logic [IDX_W-1:0]    mem_req_o_bits_idx;
    logic [MCN_W-1:0]    mem_req_o_bits_mcn;
    logic                mem_res_i_valid;
    logic                mem_res_i_ready;
    logic [IDX_W-1:0]    mem_res_i_bits_idx;
    logic [DATA_W-1:0]   mem_res_i_bits_data;
    logic                busy_o;
    logic                err_o;

    ttw_mem_arb #(.N(N), .IDX_W(IDX_W), .MCN_W(MCN_W), .DATA_W(DATA_W)) dut (
        .clock               (clock),
        .reset               (reset),
        .req_i_valid         (req_i_valid),
        .req_i_ready         (req_i_ready),
        .req_i_mcn           (req_i_mcn),
        .res_o_valid         (res_o_valid),
        .res_o_data          (res_o_data),
        .kill_i              (kill_i),
        .mem_req_o_valid     (mem_req_o_valid),
        .mem_req_o_ready     (mem_req_o_ready),
        .mem_req_o_bits_idx  (mem_req_o_bits_idx),
        .mem_req_o_bits_mcn  (mem_req_o_bits_mcn),
        .mem_res_i_valid     (mem_res_i_valid),
        .mem_res_i_ready     (mem_res_i_ready),
        .mem_res_i_bits_idx  (mem_res_i_bits_idx),
        .mem_res_i_bits_data (mem_res_i_bits_data),
        .busy_o              (busy_o),
        .err_o               (err_o)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: what the arbiter should present after the next clock edge.
    bit                m_pend [N];
    bit                m_kld  [N];
    int                m_rr;
    bit                m_vld;
    int                m_idx;
    logic [MCN_W-1:0]  m_mcn;
    logic [N-1:0]      m_res_v;
    logic [DATA_W-1:0] m_res_d;
    bit                m_err;
    bit                m_busy;
    bit                m_rdy;
    bit                known = 1'b0;

    int memq [$];
    int p_req  = 0;
    int p_kill = 0;
    int p_rdy  = 0;
    int p_rsp  = 0;
    int force_tag = -1;

    task automatic step(input bit rst);
        int           g;
        int           j;
        bit           slot_free;
        logic [N-1:0] exp_rdy;
        @(negedge clock);
        if (known) begin
            check("mem_req_valid", mem_req_o_valid, m_vld);
            if (m_vld) begin
                check("mem_req_idx", mem_req_o_bits_idx, m_idx);
                check("mem_req_mcn", mem_req_o_bits_mcn, m_mcn);
            end
            check("res_valid", res_o_valid, m_res_v);
            check("res_data", res_o_data, m_res_d);
            check("busy", busy_o, m_busy);
            check("err", err_o, m_err);
            check("mem_res_ready", mem_res_i_ready, m_rdy);
        end

        reset = rst;
        for (int k = 0; k < N; k++) begin
            req_i_valid[k] = !rst && ($urandom_range(99) < p_req);
            req_i_mcn[k*MCN_W +: MCN_W] = MCN_W'({$urandom, $urandom});
            kill_i[k] = ($urandom_range(99) < p_kill);
        end
        mem_req_o_ready = ($urandom_range(99) < p_rdy);
        for (int w = 0; w < DATA_W / 32; w++) mem_res_i_bits_data[w*32 +: 32] = $urandom;
        mem_res_i_valid    = 1'b0;
        mem_res_i_bits_idx = '0;
        if (!rst) begin
            if (force_tag >= 0) begin
                mem_res_i_valid    = 1'b1;
                mem_res_i_bits_idx = IDX_W'(force_tag);
                force_tag          = -1;
            end else if (memq.size() > 0 && $urandom_range(99) < p_rsp) begin
                int q;
                q = $urandom_range(memq.size() - 1);
                mem_res_i_valid    = 1'b1;
                mem_res_i_bits_idx = IDX_W'(memq[q]);
                memq.delete(q);
            end
        end
        #1;

        if (rst) begin
            check("req_ready_rst", req_i_ready, '0);
            for (int k = 0; k < N; k++) begin
                m_pend[k] = 1'b0;
                m_kld[k]  = 1'b0;
            end
            m_rr = 0; m_vld = 1'b0; m_idx = 0; m_mcn = '0;
            m_res_v = '0; m_res_d = '0; m_err = 1'b0; m_busy = 1'b0; m_rdy = 1'b0;
            known = 1'b1;
        end else begin
            slot_free = !m_vld || mem_req_o_ready;
            g = -1;
            if (slot_free) begin
                for (int o = 0; o < N; o++) begin
                    int k;
                    k = (m_rr + o) % N;
                    if (g < 0 && req_i_valid[k] && !m_pend[k]) g = k;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", req_i_ready, exp_rdy);

            if (m_vld && mem_req_o_ready) memq.push_back(m_idx);
            for (int k = 0; k < N; k++) begin
                if (kill_i[k] && m_pend[k]) m_kld[k] = 1'b1;
            end
            m_res_v = '0;
            if (mem_res_i_valid && m_rdy) begin
                j = int'(mem_res_i_bits_idx);
                if (m_pend[j]) begin
                    if (!m_kld[j]) begin
                        m_res_v[j] = 1'b1;
                        m_res_d    = mem_res_i_bits_data;
                    end
                    m_pend[j] = 1'b0;
                    m_kld[j]  = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (g >= 0) begin
                m_pend[g] = 1'b1;
                m_rr      = (g + 1) % N;
                m_vld     = 1'b1;
                m_idx     = g;
                m_mcn     = req_i_mcn[g*MCN_W +: MCN_W];
            end else if (slot_free) begin
                m_vld = 1'b0;
            end
            m_busy = 1'b0;
            for (int k = 0; k < N; k++) if (m_pend[k]) m_busy = 1'b1;
            m_rdy = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1;
        req_i_valid = '0; req_i_mcn = '0; kill_i = '0;
        mem_req_o_ready = 1'b0; mem_res_i_valid = 1'b0;
        mem_res_i_bits_idx = '0; mem_res_i_bits_data = '0;
        repeat (3) step(1'b1);

        // Mixed traffic, full-rate fairness, heavy backpressure, heavy kills.
        for (int r = 0; r < 4; r++) begin
            case (r)
                0: begin p_req = 30;  p_rdy = 80;  p_rsp = 40;  p_kill = 3;  end
                1: begin p_req = 100; p_rdy = 100; p_rsp = 100; p_kill = 0;  end
                2: begin p_req = 70;  p_rdy = 20;  p_rsp = 50;  p_kill = 5;  end
                default: begin p_req = 60; p_rdy = 70; p_rsp = 30; p_kill = 25; end
            endcase
            repeat (500) step(1'b0);
        end

        // Reset mid-operation, then a response for a tag nothing is waiting on.
        repeat (2) step(1'b1);
        p_req = 0; p_rsp = 0; p_kill = 0;
        repeat (2) step(1'b0);
        force_tag = 2;
        step(1'b0);
        p_rsp = 100;
        repeat (6) step(1'b0);
        check("err_sticky", err_o, 1'b1);

        // Reset clears the sticky error; resume traffic with no stale responses.
        repeat (2) step(1'b1);
        memq.delete();
        check("err_after_reset", err_o, 1'b0);
        p_req = 50; p_rdy = 60; p_rsp = 50; p_kill = 8;
        repeat (1000) step(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ttw_mem_arb.md
Name: ttw_mem_arb

Overview:
- Shares the single table-walker memory port (mem_req/mem_res, ttw-tagged) among N walker requesters.
- Round-robin arbitrates requests, tags each with the requester index, and routes the 512-bit responses back by that tag.
- Limits each requester to one outstanding request and supports per-requester kill so stale walks are dropped on return.
- Sits between the VLB walker slots and the memory-side adapter.

Parameters:
- N, 4, number of walker requesters
- IDX_W, 2, tag width (clog2(N)); equals the ttw index width
- MCN_W, 58, memory cache-line number width
- DATA_W, 512, response line width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_i_valid  in  N  per-requester request valid
- req_i_ready  out  N  per-requester request accept
- req_i_mcn  in  N*MCN_W  per-requester line number; slice k is [k*MCN_W +: MCN_W]
- res_o_valid  out  N  one-hot response pulse to the owning requester
- res_o_data  out  DATA_W  response data, shared by all requesters
- kill_i  in  N  drop the outstanding request of requester k on return
- mem_req_o_valid  out  1  memory request valid
- mem_req_o_ready  in  1  memory request accept
- mem_req_o_bits_idx  out  IDX_W  requester tag
- mem_req_o_bits_mcn  out  MCN_W  line number
- mem_res_i_valid  in  1  memory response valid
- mem_res_i_ready  out  1  response accept; tied to 1 once out of reset
- mem_res_i_bits_idx  in  IDX_W  response tag
- mem_res_i_bits_data  in  DATA_W  response line
- busy_o  out  1  any request pending
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (synchronous, active-high):
  - Output values: mem_req_o_valid=0, req_i_ready=0, res_o_valid=0, res_o_data=0, mem_res_i_ready=0, busy_o=0, err_o=0.
  - Internal state: pend=0, kld=0, rr pointer=0.
  - mem_res_i_ready=1 from the first cycle after reset deasserts.
- Request registers:
  - The request slot is the register set mem_req_o_valid, mem_req_o_bits_idx and mem_req_o_bits_mcn.
  - The slot is free when mem_req_o_valid=0, or when mem_req_o_valid && mem_req_o_ready.
- Eligibility: requester k is eligible when req_i_valid[k] && !pend[k].
- Grant:
  - When the slot is free, the arbiter grants the first eligible k at or after rr, in ascending order with wrap-around.
  - req_i_ready[k]=1 combinationally in that cycle, for the granted k only.
- Grant latency:
  - A grant in cycle t sets mem_req_o_valid=1 in t+1, with idx=k and mcn=slice k.
  - In the same edge it sets pend[k]=1 and moves rr to (k+1) mod N.
- Back-to-back: the slot can be accepted and reloaded in the same cycle, giving a throughput of 1 request per cycle.
- Hold rule: while mem_req_o_valid && !mem_req_o_ready, idx and mcn hold stable and no grant occurs.
- Response handling:
  - A response is accepted when mem_res_i_valid is high, with tag j = mem_res_i_bits_idx.
  - If pend[j] && !kld[j] && !kill_i[j]: in the next cycle res_o_valid = one-hot(j) for 1 cycle and res_o_data = the response data.
  - If pend[j] and the request is killed (kld[j] or kill_i[j]): the response is dropped and res_o_valid stays 0.
  - In every accepted-response case with pend[j] set, pend[j] and kld[j] clear at the end of that cycle.
  - If !pend[j]: the response is dropped and err_o latches 1 until reset.
  - res_o_data holds its last value when no response is delivered.
- Kill:
  - kill_i[k] with pend[k] set sets kld[k]=1.
  - kill_i[k] with pend[k] clear has no effect.
  - A killed request still in the slot is still issued, because valid is never retracted.
  - kill_i[k] in the same cycle as k's response drops that response.
- Same requester, same cycle: when k's response and req_i_valid[k] coincide, pend[k] is still 1 in that cycle, so no grant to k. k is eligible from the next cycle.
- Response during grant: a response and a grant may occur in the same cycle for different requesters.
- busy_o = |pend, registered from pend; it is 1 from the cycle after a grant until the cycle after the last response.
- Reset mid-operation: all pend and kld state is lost. Any later response for those tags sets err_o.

Test Plan:
- Single request:
  - Stimulus: req 0, mcn=0x123, mem ready=1; response idx0 with data=0xAA..AA 3 cycles after issue.
  - Required: mem_req_o_valid=1 with idx0 and mcn 0x123 one cycle after the grant; res_o_valid=0001 and data=0xAA..AA one cycle after the response; busy_o returns to 0.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold valid, mem ready=1, responses return immediately.
  - Required: grant order 0,1,2,3,0; no requester is granted twice before all others.
- Backpressure:
  - Stimulus: mem ready=0 for 5 cycles with req 2 (mcn=0x55) pending in the slot.
  - Required: idx and mcn stay stable at 2 and 0x55; req_i_ready=0 for all other requesters; the request issues on the cycle ready=1.
- One outstanding per requester:
  - Stimulus: req 1 holds valid after its grant, before its response arrives.
  - Required: req_i_ready[1]=0 until the cycle after the response; the regrant comes at the earliest in that cycle.
- Kill:
  - Stimulus: grant req 3, then kill_i[3] pulses before the response; separately, kill_i[1] is pulsed in the same cycle as a response tagged idx1.
  - Required: both responses are dropped with res_o_valid=0; pend clears; err_o stays 0.
- Protocol error and reset:
  - Stimulus: a response with idx2 while nothing is pending; then reset.
  - Required: err_o=1 stays sticky until reset; all outputs return to their reset values.
